// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: frames one IMG_W x IMG_H image through a KxK window generator.
// Define CONV_WINDOW_STRIDE2_EN to flag only stride-2 window positions.
module conv_window_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int CNT_W = 5,
  parameter int OUT_W = 10
) (
  input  logic             iClk,
  input  logic             iRsn,
  input  logic             iStart,
  input  logic             iPixelValid,
  output logic             oPixelReady,
  output logic             oShiftEn,
  output logic [CNT_W-1:0] oCol,
  output logic [CNT_W-1:0] oRow,
  output logic             oWindowValid,
  input  logic             iWindowReady,
  output logic             oBusy,
  output logic             oFrameDone,
  output logic [OUT_W-1:0] oWinCount
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] WIN_START = CNT_W'(K - 1);

  state_t state;
  logic   accept;
  logic   handshake;
  logic   lastPixel;
  logic   winPixel;

  // An unconsumed window blocks the stream, but a consumed one lets a pixel in the same cycle.
  always_comb begin
    oPixelReady = (state == RUN) && !(oWindowValid && !iWindowReady);
  end

  assign oShiftEn  = iPixelValid & oPixelReady;
  assign accept    = oShiftEn;
  assign handshake = oWindowValid & iWindowReady;
  assign lastPixel = (oRow == LAST_ROW) && (oCol == LAST_COL);

`ifdef CONV_WINDOW_STRIDE2_EN
  logic [CNT_W-1:0] rowOff;
  logic [CNT_W-1:0] colOff;

  assign rowOff   = oRow - WIN_START;
  assign colOff   = oCol - WIN_START;
  assign winPixel = accept && (oRow >= WIN_START) && (oCol >= WIN_START)
                    && !rowOff[0] && !colOff[0];
`else
  assign winPixel = accept && (oRow >= WIN_START) && (oCol >= WIN_START);
`endif

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      state        <= IDLE;
      oCol         <= '0;
      oRow         <= '0;
      oWinCount    <= '0;
      oWindowValid <= 1'b0;
      oFrameDone   <= 1'b0;
      oBusy        <= 1'b0;
    end else begin
      oFrameDone <= 1'b0;

      if (winPixel) begin
        oWindowValid <= 1'b1;
      end else if (handshake) begin
        oWindowValid <= 1'b0;
      end

      if (handshake) begin
        oWinCount <= oWinCount + OUT_W'(1);
      end

      case (state)
        IDLE: begin
          if (iStart) begin
            state     <= RUN;
            oBusy     <= 1'b1;
            oWinCount <= '0;
            oRow      <= '0;
            oCol      <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (oCol == LAST_COL) begin
              oCol <= '0;
              if (lastPixel) begin
                oRow  <= '0;
                state <= DRAIN;
              end else begin
                oRow <= oRow + CNT_W'(1);
              end
            end else begin
              oCol <= oCol + CNT_W'(1);
            end
          end
        end
        // The last pixel's window, if any, must be consumed before the frame closes.
        DRAIN: begin
          if (!oWindowValid || handshake) begin
            state      <= DONE;
            oFrameDone <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: directed frames against conv_window_ctrl with hand-computed totals.
// Honours CONV_WINDOW_STRIDE2_EN for the stride-2 expectations.
module tb_conv_window_ctrl;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 3;
  localparam int CNT_W = 5;
  localparam int OUT_W = 10;
  localparam int NPIX  = IMG_W * IMG_H;

`ifdef CONV_WINDOW_STRIDE2_EN
  localparam int EXP_WIN      = 169;
  localparam int SECOND_ACC   = 61;
  localparam int STALL_ACC    = 123;
  localparam int LAST_WIN_ACC = 755;
  localparam int DONE_DELAY   = 30;
  localparam int WIN_AT_100   = 13;
`else
  localparam int EXP_WIN      = 676;
  localparam int SECOND_ACC   = 60;
  localparam int STALL_ACC    = 151;
  localparam int LAST_WIN_ACC = 784;
  localparam int DONE_DELAY   = 1;
  localparam int WIN_AT_100   = 40;
`endif

  logic             iClk = 1'b0;
  logic             iRsn;
  logic             iStart;
  logic             iPixelValid;
  logic             iWindowReady;
  logic             oPixelReady;
  logic             oShiftEn;
  logic [CNT_W-1:0] oCol;
  logic [CNT_W-1:0] oRow;
  logic             oWindowValid;
  logic             oBusy;
  logic             oFrameDone;
  logic [OUT_W-1:0] oWinCount;

  int testsRun = 0;
  int testsFailed = 0;
  int accCnt, hsCnt, doneCnt, cycCnt, firstHsAcc, secondHsAcc, lastHsCyc, doneCyc;

  conv_window_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .CNT_W(CNT_W), .OUT_W(OUT_W)
  ) dut (
    .iClk(iClk), .iRsn(iRsn), .iStart(iStart), .iPixelValid(iPixelValid),
    .oPixelReady(oPixelReady), .oShiftEn(oShiftEn), .oCol(oCol), .oRow(oRow),
    .oWindowValid(oWindowValid), .iWindowReady(iWindowReady), .oBusy(oBusy),
    .oFrameDone(oFrameDone), .oWinCount(oWinCount)
  );

  always #5 iClk = ~iClk;

  // Sample one cycle at the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge iClk);
    cycCnt++;
    if (oWindowValid && iWindowReady) begin
      if (hsCnt == 0) firstHsAcc = accCnt;
      else if (hsCnt == 1) secondHsAcc = accCnt;
      hsCnt++;
      lastHsCyc = cycCnt;
    end
    if (oShiftEn) accCnt++;
    if (oFrameDone) begin
      doneCnt++;
      doneCyc = cycCnt;
    end
    @(posedge iClk);
    #1;
  endtask

  task automatic clear_counts();
    accCnt = 0; hsCnt = 0; doneCnt = 0; cycCnt = 0;
    firstHsAcc = -1; secondHsAcc = -1; lastHsCyc = -1; doneCyc = -1;
  endtask

  task automatic start_frame();
    clear_counts();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic stream(input int budget, output bit timedOut);
    int n = 0;
    iPixelValid = 1'b1;
    iWindowReady = 1'b1;
    while (doneCnt == 0 && n < budget) begin
      tick();
      n++;
    end
    timedOut = (doneCnt == 0);
  endtask

  task automatic test_reset();
    iRsn = 1'b0; iStart = 1'b0; iPixelValid = 1'b0; iWindowReady = 1'b0;
    clear_counts();
    tick(); tick();
    testsRun++;
    if (oCol !== '0 || oRow !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset position: got row %0d col %0d, expected 0 0", oRow, oCol);
    end
    testsRun++;
    if (oWinCount !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset wincount: got %0d, expected 0", oWinCount);
    end
    testsRun++;
    if (oWindowValid !== 1'b0 || oFrameDone !== 1'b0 || oBusy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset flags: got wv %b done %b busy %b, expected 0 0 0",
               oWindowValid, oFrameDone, oBusy);
    end
    iRsn = 1'b1;
    iPixelValid = 1'b1;
    tick();
    #1;
    testsRun++;
    if (oPixelReady !== 1'b0 || oShiftEn !== 1'b0 || oBusy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL idle ready: got ready %b shift %b busy %b, expected 0 0 0",
               oPixelReady, oShiftEn, oBusy);
    end
  endtask

  task automatic test_continuous();
    bit to;
    start_frame();
    testsRun++;
    if (oBusy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL start busy: got %b, expected 1", oBusy);
    end
    stream(1500, to);
    testsRun++;
    if (to) begin
      testsFailed++;
      $display("[TB] FAIL continuous timeout: got no frame done, expected one");
    end
    testsRun++;
    if (firstHsAcc !== 59 || secondHsAcc !== SECOND_ACC) begin
      testsFailed++;
      $display("[TB] FAIL first windows: got after accepts %0d %0d, expected 59 %0d",
               firstHsAcc, secondHsAcc, SECOND_ACC);
    end
    testsRun++;
    if (hsCnt !== EXP_WIN || oWinCount !== OUT_W'(EXP_WIN)) begin
      testsFailed++;
      $display("[TB] FAIL continuous windows: got hs %0d count %0d, expected %0d",
               hsCnt, oWinCount, EXP_WIN);
    end
    testsRun++;
    if (doneCnt !== 1 || accCnt !== NPIX) begin
      testsFailed++;
      $display("[TB] FAIL continuous done/accepts: got %0d %0d, expected 1 %0d",
               doneCnt, accCnt, NPIX);
    end
    testsRun++;
    if (oBusy !== 1'b0 || oFrameDone !== 1'b0 || oRow !== '0 || oCol !== '0) begin
      testsFailed++;
      $display("[TB] FAIL after frame: got busy %b done %b row %0d col %0d, expected 0 0 0 0",
               oBusy, oFrameDone, oRow, oCol);
    end
    tick(); tick(); tick();
    testsRun++;
    if (oWinCount !== OUT_W'(EXP_WIN) || doneCnt !== 1) begin
      testsFailed++;
      $display("[TB] FAIL count hold: got %0d done %0d, expected %0d done 1",
               oWinCount, doneCnt, EXP_WIN);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int stallLeft = 5;
    int stalls = 0;
    start_frame();
    iPixelValid = 1'b1;
    while (doneCnt == 0 && n < 2000) begin
      if (accCnt == STALL_ACC && oWindowValid && stallLeft > 0) begin
        iWindowReady = 1'b0;
        #1;
        testsRun++;
        if (oPixelReady !== 1'b0 || oShiftEn !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL stall gating: got ready %b shift %b, expected 0 0",
                   oPixelReady, oShiftEn);
        end
        testsRun++;
        if (oRow !== CNT_W'(STALL_ACC / IMG_W) || oCol !== CNT_W'(STALL_ACC % IMG_W)) begin
          testsFailed++;
          $display("[TB] FAIL stall position: got %0d,%0d, expected %0d,%0d",
                   oRow, oCol, STALL_ACC / IMG_W, STALL_ACC % IMG_W);
        end
        stallLeft--;
        stalls++;
      end else begin
        iWindowReady = 1'b1;
      end
      tick();
      n++;
    end
    iWindowReady = 1'b1;
    testsRun++;
    if (stalls !== 5) begin
      testsFailed++;
      $display("[TB] FAIL stall length: got %0d held cycles, expected 5", stalls);
    end
    testsRun++;
    if (hsCnt !== EXP_WIN || oWinCount !== OUT_W'(EXP_WIN) || accCnt !== NPIX || doneCnt !== 1) begin
      testsFailed++;
      $display("[TB] FAIL backpressure totals: got hs %0d count %0d acc %0d done %0d, expected %0d %0d %0d 1",
               hsCnt, oWinCount, accCnt, doneCnt, EXP_WIN, EXP_WIN, NPIX);
    end
  endtask

  task automatic test_gaps();
    int n = 0;
    int posErr = 0;
    bit wrapChecked = 1'b0;
    start_frame();
    iWindowReady = 1'b1;
    iPixelValid = 1'b0;
    while (doneCnt == 0 && n < 4000) begin
      iPixelValid = ~iPixelValid;
      tick();
      n++;
      if (oCol !== CNT_W'(accCnt % IMG_W) || oRow !== CNT_W'((accCnt % NPIX) / IMG_W)) posErr++;
      if (accCnt == IMG_W && !wrapChecked) begin
        wrapChecked = 1'b1;
        testsRun++;
        if (oCol !== '0 || oRow !== CNT_W'(1)) begin
          testsFailed++;
          $display("[TB] FAIL gap wrap: got row %0d col %0d, expected 1 0", oRow, oCol);
        end
      end
    end
    testsRun++;
    if (posErr !== 0 || !wrapChecked) begin
      testsFailed++;
      $display("[TB] FAIL gap tracking: got %0d position errors (wrap seen %b), expected 0 (1)",
               posErr, wrapChecked);
    end
    testsRun++;
    if (hsCnt !== EXP_WIN || accCnt !== NPIX || doneCnt !== 1) begin
      testsFailed++;
      $display("[TB] FAIL gap totals: got hs %0d acc %0d done %0d, expected %0d %0d 1",
               hsCnt, accCnt, doneCnt, EXP_WIN, NPIX);
    end
  endtask

  task automatic test_start_busy_reset();
    int n = 0;
    bit to;
    start_frame();
    iPixelValid = 1'b1;
    iWindowReady = 1'b1;
    while (accCnt < 100 && n < 500) begin tick(); n++; end
    iPixelValid = 1'b0;
    tick(); tick();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick();
    testsRun++;
    if (oRow !== CNT_W'(3) || oCol !== CNT_W'(16) || oBusy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL start ignored position: got row %0d col %0d busy %b, expected 3 16 1",
               oRow, oCol, oBusy);
    end
    testsRun++;
    if (oWinCount !== OUT_W'(WIN_AT_100) || oWindowValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL start ignored count: got %0d wv %b, expected %0d 0",
               oWinCount, oWindowValid, WIN_AT_100);
    end
    iPixelValid = 1'b1;
    n = 0;
    while (accCnt < 280 && n < 1000) begin tick(); n++; end
    testsRun++;
    if (oRow !== CNT_W'(10) || oCol !== '0) begin
      testsFailed++;
      $display("[TB] FAIL row ten: got row %0d col %0d, expected 10 0", oRow, oCol);
    end
    iRsn = 1'b0;
    tick();
    iRsn = 1'b1;
    testsRun++;
    if (oRow !== '0 || oCol !== '0 || oWinCount !== '0 || oWindowValid !== 1'b0
        || oBusy !== 1'b0 || oFrameDone !== 1'b0 || oPixelReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid-frame reset: got row %0d col %0d cnt %0d wv %b busy %b done %b rdy %b, expected all 0",
               oRow, oCol, oWinCount, oWindowValid, oBusy, oFrameDone, oPixelReady);
    end
    repeat (5) tick();
    testsRun++;
    if (doneCnt !== 0 || oCol !== '0 || oBusy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort quiet: got done %0d col %0d busy %b, expected 0 0 0",
               doneCnt, oCol, oBusy);
    end
    start_frame();
    stream(1500, to);
    testsRun++;
    if (to || hsCnt !== EXP_WIN || oWinCount !== OUT_W'(EXP_WIN) || doneCnt !== 1 || accCnt !== NPIX) begin
      testsFailed++;
      $display("[TB] FAIL restart frame: got hs %0d count %0d done %0d acc %0d, expected %0d %0d 1 %0d",
               hsCnt, oWinCount, doneCnt, accCnt, EXP_WIN, EXP_WIN, NPIX);
    end
  endtask

  task automatic test_final_backpressure();
    int n = 0;
    int stallLeft = 3;
    int stalls = 0;
    start_frame();
    iPixelValid = 1'b1;
    while (doneCnt == 0 && n < 2000) begin
      if (accCnt == LAST_WIN_ACC && oWindowValid && stallLeft > 0) begin
        iWindowReady = 1'b0;
        #1;
        testsRun++;
        if (oBusy !== 1'b1 || oFrameDone !== 1'b0 || oPixelReady !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL last stall: got busy %b done %b ready %b, expected 1 0 0",
                   oBusy, oFrameDone, oPixelReady);
        end
        stallLeft--;
        stalls++;
      end else begin
        iWindowReady = 1'b1;
      end
      tick();
      n++;
    end
    iWindowReady = 1'b1;
    testsRun++;
    if (stalls !== 3) begin
      testsFailed++;
      $display("[TB] FAIL last stall length: got %0d, expected 3", stalls);
    end
    testsRun++;
    if (doneCnt !== 1 || doneCyc - lastHsCyc !== DONE_DELAY) begin
      testsFailed++;
      $display("[TB] FAIL done timing: got %0d pulses, delay %0d, expected 1 pulse, delay %0d",
               doneCnt, doneCyc - lastHsCyc, DONE_DELAY);
    end
    testsRun++;
    if (hsCnt !== EXP_WIN || oWinCount !== OUT_W'(EXP_WIN) || oBusy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL last stall totals: got hs %0d count %0d busy %b, expected %0d %0d 0",
               hsCnt, oWinCount, oBusy, EXP_WIN, EXP_WIN);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_backpressure();
    test_gaps();
    test_start_busy_reset();
    test_final_backpressure();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
Sequencing controller for the 3x3 sliding-window generator feeding the conv engine.
- Frames one IMG_W x IMG_H image per iStart and gates pixel acceptance with a valid/ready handshake.
- Drives the window generator's shift enable and tracks row/column position.
- Flags which accepted pixels complete a legal KxK window and stalls the pixel stream while the conv engine back-pressures.
- Signals frame completion.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
K, 3, window size
CNT_W, 5, row/column counter width; must satisfy 2^CNT_W >= max(IMG_W, IMG_H)
OUT_W, 10, window counter width; must hold (IMG_W-K+1)*(IMG_H-K+1)

Ports:
iClk  in  1  clock, rising edge
iRsn  in  1  reset, synchronous, active-low
iStart  in  1  single-cycle frame start request
iPixelValid  in  1  upstream pixel valid
oPixelReady  out  1  controller can accept a pixel this cycle
oShiftEn  out  1  write/shift enable to window generator (= iPixelValid & oPixelReady, combinational)
oCol  out  CNT_W  column of the next pixel to be accepted
oRow  out  CNT_W  row of the next pixel to be accepted
oWindowValid  out  1  window generator output holds a legal window
iWindowReady  in  1  conv engine consumes the window
oBusy  out  1  frame in progress (state != IDLE)
oFrameDone  out  1  single-cycle pulse at end of frame
oWinCount  out  OUT_W  windows handed off in current/last frame

Behaviour:
- Reset (iRsn=0 at posedge): state IDLE. oCol, oRow, oWinCount = 0; oWindowValid, oFrameDone, oBusy = 0. Reset mid-frame aborts with no oFrameDone.
- Accept event: iPixelValid & oPixelReady.
- Window handshake: oWindowValid & iWindowReady.
- oPixelReady = (state==RUN) & ~(oWindowValid & ~iWindowReady).
  - A pending unconsumed window stalls input.
  - Input is accepted in the same cycle as a handshake.
- FSM:
  - IDLE: oPixelReady=0. On iStart, go to RUN; clear oWinCount, oRow, oCol.
  - RUN: on each accept:
    - If oCol==IMG_W-1: oCol<=0, oRow<=oRow+1. Otherwise oCol<=oCol+1.
    - Accept of pixel (IMG_H-1, IMG_W-1): go to DRAIN; oRow/oCol wrap to 0.
  - DRAIN: oPixelReady=0. Leave for DONE in the cycle after oWindowValid is low, or directly on the final window handshake.
  - DONE: oFrameDone=1 for exactly one cycle, then IDLE.
- iStart outside IDLE is ignored.
- Window flag:
  - oWindowValid is registered: set in the cycle after accepting pixel (r,c) with r>=K-1 and c>=K-1. This is 1-cycle latency, aligned with the generator's registered output.
  - Cleared on handshake unless the same cycle accepts another window-completing pixel; in that case it stays 1.
  - Held stable while iWindowReady=0.
- oWinCount increments on each handshake and holds after DONE until the next iStart.
- Expected total: (IMG_W-K+1)*(IMG_H-K+1) = 676 for defaults.
- Gaps in iPixelValid: counters hold, no state change.
- oBusy = 1 in RUN, DRAIN, DONE.

Optional Feature:
Macro: CONV_WINDOW_STRIDE2_EN
- Defined: stride 2. oWindowValid is set only when (r-(K-1)) and (c-(K-1)) are both even. Defaults give 13x13 = 169 windows. Non-window pixels are still accepted and shifted.
- Undefined: stride 1, as described above.

Test Plan:
- Continuous stream:
  - Stimulus: reset, iStart, 784 pixels with iPixelValid=1, iWindowReady=1.
  - First oWindowValid the cycle after the 59th accept (r=2, c=2).
  - 676 handshakes; oFrameDone pulses once; oWinCount=676; oBusy low afterward.
- Backpressure:
  - Stimulus: hold iWindowReady=0 for 5 cycles at the window for (5,10).
  - oPixelReady=0 and oShiftEn=0 for those 5 cycles; oWindowValid held; no pixel lost; total still 676.
- Input gaps:
  - Stimulus: iPixelValid toggles 1/0 each cycle.
  - oCol/oRow advance only on accepts; oCol wraps 27->0 with oRow+1; 676 windows.
- Start while busy, then reset:
  - Stimulus: iStart pulsed mid-frame.
  - No effect on counters.
  - Stimulus: iRsn=0 at row 10.
  - All outputs 0, no oFrameDone.
  - Stimulus: new iStart.
  - Clean 676-window frame.
- Final window backpressured:
  - Stimulus: iWindowReady=0 for 3 cycles on the last window.
  - Stays in DRAIN; oFrameDone exactly one cycle after the final handshake.
- CONV_WINDOW_STRIDE2_EN defined, continuous stream:
  - 169 windows; first at r=2, c=2, second at r=2, c=4; oWinCount=169.
